// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer.
// Collects one serial bit per enabled cycle into a SIZE-bit word and hands completed words to a
// consumer over a valid/ready handshake on a registered output. A word that completes while the
// previous one is still unaccepted is dropped and raises a sticky overrun flag.
// SHIFT_DIR selects bit order: 0 = first bit into out[0], 1 = first bit into out[SIZE-1].
// Optional feature, macro SIPO_PARITY_EN: each frame carries one trailing even-parity bit that is
// checked but never stored; parity_err follows the word on out. Without the macro parity_err is 0.

module sipo_deser #(
   parameter int unsigned SIZE      = 8,
   parameter int unsigned SHIFT_DIR = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in,
   input  logic            enable,
   input  logic            clear,
   output logic [SIZE-1:0] out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            done,
   output logic            busy,
   output logic            overrun,
   output logic            parity_err
);

`ifdef SIPO_PARITY_EN
   localparam int unsigned FRAME = SIZE + 1;
`else
   localparam int unsigned FRAME = SIZE;
`endif
   localparam int unsigned CW = $clog2(FRAME + 1);

   // Counter value of the last bit of a frame, and the highest data position.
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
   localparam logic [CW-1:0] TOP_POS  = CW'(SIZE - 1);
   localparam logic [CW-1:0] DATA_LEN = CW'(SIZE);

   logic [SIZE-1:0] shreg_q, shreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            overrun_q, overrun_d;

   logic [CW-1:0]   pos;
   logic [SIZE-1:0] word;
   logic            accept;
   logic            last_bit;

`ifdef SIPO_PARITY_EN
   logic parity_err_q, parity_err_d;
   logic parity_bad;

   // Even parity: data bits plus the parity bit must XOR to zero.
   assign parity_bad = (^shreg_q) ^ in;
`endif

   assign accept   = out_valid_q & out_ready;
   assign last_bit = (cnt_q == LAST_CNT);

   // Assemble the word as it would look with the current bit placed at its position. Bits are
   // written in place rather than shifted, so earlier bits never move. The parity bit slot
   // (counter == SIZE) falls outside the data range and writes nothing.
   always_comb begin
      word = shreg_q;
      pos  = (SHIFT_DIR == 0) ? cnt_q : (TOP_POS - cnt_q);
      if (cnt_q < DATA_LEN) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            if (pos == CW'(i)) begin
               word[i] = in;
            end
         end
      end
   end

   // Next-state logic: clear flushes everything except out; otherwise handle the handshake and
   // then bit capture, with a completing frame allowed to refill out in the accept cycle.
   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      overrun_d   = overrun_q;
`ifdef SIPO_PARITY_EN
      parity_err_d = parity_err_q;
`endif

      if (clear) begin
         shreg_d     = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end else begin
         if (accept) begin
            out_valid_d = 1'b0;
         end

         if (enable) begin
            if (last_bit) begin
               cnt_d   = '0;
               shreg_d = '0;
               done_d  = 1'b1;
               // Deliver when out is free or being accepted this very cycle; otherwise drop.
               if (!out_valid_q || accept) begin
                  out_d       = word;
                  out_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                  parity_err_d = parity_bad;
`endif
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               shreg_d = word;
               cnt_d   = cnt_q + 1'b1;
            end
         end
      end

      busy_d = (cnt_d != '0);
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q     <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef SIPO_PARITY_EN
   // Parity status travels with the delivered word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser. Two instances share all inputs: one LSB-first and
// one MSB-first, so the MSB instance must always show the bit-reversed word of the LSB one.
// With SIPO_PARITY_EN defined the bench appends a parity bit to every frame.

module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FR = PAR ? 9 : 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       ser;
   logic       enable;
   logic       clear;
   logic       out_ready;

   logic [7:0] out_l, out_m;
   logic       valid_l, valid_m, done_l, done_m, busy_l, busy_m;
   logic       ovr_l, ovr_m, perr_l, perr_m;

   int n_cmp = 0;
   int n_err = 0;
   int low_cnt;

   always #5 clk = ~clk;

   sipo_deser #(.SIZE(8), .SHIFT_DIR(0)) u_lsb (
      .clk(clk), .reset(reset), .in(ser), .enable(enable), .clear(clear),
      .out(out_l), .out_valid(valid_l), .out_ready(out_ready), .done(done_l),
      .busy(busy_l), .overrun(ovr_l), .parity_err(perr_l)
   );

   sipo_deser #(.SIZE(8), .SHIFT_DIR(1)) u_msb (
      .clk(clk), .reset(reset), .in(ser), .enable(enable), .clear(clear),
      .out(out_m), .out_valid(valid_m), .out_ready(out_ready), .done(done_m),
      .busy(busy_m), .overrun(ovr_m), .parity_err(perr_m)
   );

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!valid_l) low_cnt++;
   endtask

   // Send one frame, first bit = w[0]. gap idle cycles follow each bit. pflip corrupts parity.
   // rl raises out_ready together with the final bit of the frame.
   task automatic send_word(input logic [7:0] w, input int gap, input bit pflip, input bit rl);
      for (int i = 0; i < FR; i++) begin
         enable = 1'b1;
         ser    = (i < 8) ? w[i] : ((^w) ^ pflip);
         if (rl && i == FR - 1) out_ready = 1'b1;
         tick();
         enable = 1'b0;
         for (int g = 0; g < gap; g++) tick();
      end
      enable = 1'b0;
   endtask

   // Outputs of both instances packed for compact comparison:
   // {valid, done, busy, overrun, parity_err} per instance.
   function automatic logic [9:0] flags();
      return {valid_l, done_l, busy_l, ovr_l, perr_l, valid_m, done_m, busy_m, ovr_m, perr_m};
   endfunction

   initial begin
      reset     = 1'b1;
      ser       = 1'b0;
      enable    = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      low_cnt   = 0;

      // Reset state
      repeat (2) tick();
      check("reset_out", {out_l, out_m}, 16'h0000);
      check("reset_flags", flags(), 10'b0);
      reset = 1'b0;
      tick();
      check("idle_flags", flags(), 10'b0);

      // LSB-first delivery with busy tracking
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         enable = 1'b1;
         ser    = 8'hA5 >> i;
         tick();
         check($sformatf("t1_busy_bit%0d", i + 1), busy_l, (i < 7) ? 1'b1 : PAR);
         if (i < 7 || PAR) check($sformatf("t1_nodone_bit%0d", i + 1), done_l, 1'b0);
      end
      if (PAR) begin
         ser = 1'b0;
         tick();
      end
      enable = 1'b0;
      check("t1_out", {out_l, out_m}, {8'hA5, rev8(8'hA5)});
      check("t1_valid_done", {valid_l, done_l, busy_l}, 3'b110);
      tick();
      check("t1_done_once", {done_l, done_m}, 2'b00);
      check("t1_accepted", {valid_l, valid_m}, 2'b00);
      check("t1_out_kept", out_l, 8'hA5);

      // Gapped enable, both bit orders
      out_ready = 1'b0;
      send_word(8'hA5, 1, 1'b0, 1'b0);
      check("t2_out_gap", {out_l, out_m}, {8'hA5, 8'hA5});
      check("t2_valid_gap", {valid_l, valid_m, busy_l}, 3'b110);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      send_word(8'h12, 0, 1'b0, 1'b0);
      check("t2_out_order", {out_l, out_m}, {8'h12, 8'h48});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t2_drained", valid_l, 1'b0);

      // Backpressure and overrun
      send_word(8'h11, 0, 1'b0, 1'b0);
      check("t3_first", {out_l, 7'b0, valid_l, 7'b0, ovr_l}, {8'h11, 8'h01, 8'h00});
      send_word(8'h22, 0, 1'b0, 1'b0);
      check("t3_dropped_out", {out_l, out_m}, {8'h11, rev8(8'h11)});
      check("t3_overrun", {valid_l, done_l, ovr_l, ovr_m}, 4'b1111);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_accept", {valid_l, ovr_l}, 2'b01);
      check("t3_out_hold", out_l, 8'h11);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t3_clear", {ovr_l, ovr_m, perr_l, valid_l}, 4'b0000);
      check("t3_clear_out", out_l, 8'h11);

      // Completion and acceptance in the same cycle
      send_word(8'h3C, 0, 1'b0, 1'b0);
      low_cnt = 0;
      send_word(8'hC3, 0, 1'b0, 1'b1);
      out_ready = 1'b0;
      check("t4_out", {out_l, out_m}, {8'hC3, rev8(8'hC3)});
      check("t4_valid_ovr", {valid_l, ovr_l}, 2'b10);
      check("t4_no_bubble", low_cnt, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Clear mid-word discards partial bits and the bit presented with clear
      for (int i = 0; i < 4; i++) begin
         enable = 1'b1;
         ser    = 1'b1;
         tick();
      end
      check("t5_busy_mid", busy_l, 1'b1);
      clear = 1'b1;
      tick();
      clear  = 1'b0;
      enable = 1'b0;
      check("t5_clear_busy", {busy_l, busy_m}, 2'b00);
      send_word(8'h5A, 0, 1'b0, 1'b0);
      check("t5_after_clear", {out_l, out_m}, {8'h5A, rev8(8'h5A)});

      // Asynchronous reset mid-word while a word is pending
      for (int i = 0; i < 3; i++) begin
         enable = 1'b1;
         ser    = 1'b1;
         tick();
      end
      enable = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("t5_async_out", {out_l, out_m}, 16'h0000);
      check("t5_async_flags", flags(), 10'b0);
      tick();
      reset = 1'b0;
      send_word(8'h96, 0, 1'b0, 1'b0);
      check("t5_post_reset", {out_l, out_m}, {8'h96, 8'h69});
      check("t5_post_valid", {valid_l, valid_m, ovr_l}, 3'b110);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Parity status
      send_word(8'hA5, 0, 1'b0, 1'b0);
      check("t6_par_ok", {out_l, 7'b0, perr_l, 7'b0, perr_m}, {8'hA5, 8'h00, 8'h00});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      send_word(8'hA5, 0, 1'b1, 1'b0);
      check("t6_par_bad", {out_l, 7'b0, perr_l, 7'b0, perr_m}, {8'hA5, 7'b0, PAR, 7'b0, PAR});
      check("t6_par_valid", valid_l, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in parallel-out deserializer; receive-side counterpart of the team's parallel-to-serial shifter.
- Samples one serial bit per cycle in which `enable` is high and assembles SIZE-bit words.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags words lost to backpressure. Sits between a serial link front-end and word-oriented consumer logic.

Parameters:
- SIZE, 8: word width in bits; legal range >= 2.
- SHIFT_DIR, 0: bit order. 0 = first received bit lands in out[0] (LSB-first). 1 = first received bit lands in out[SIZE-1] (MSB-first).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in  input  1  serial data bit; sampled only when enable=1.
- enable  input  1  bit strobe; one bit consumed per cycle high.
- clear  input  1  synchronous flush; priority over enable.
- out  output  SIZE  last delivered word.
- out_valid  output  1  out holds a word not yet accepted.
- out_ready  input  1  consumer accepts out when out_valid && out_ready.
- done  output  1  one-cycle pulse on the edge a frame completes.
- busy  output  1  partial word in progress (bit counter != 0).
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  parity status of the word on out (see Optional Feature).

Behaviour:
- Reset values: clock `clk`; reset `reset`, asynchronous, active-high. Under reset:
  - out=0, out_valid=0, done=0, busy=0, overrun=0, parity_err=0.
  - Internal shift register = 0; bit counter = 0.
- Bit counter width is $clog2(FRAME+1). FRAME = SIZE, or SIZE+1 with parity enabled.
- Bit placement, for k = counter value 0..SIZE-1:
  - SHIFT_DIR=0: the bit is written to position k.
  - SHIFT_DIR=1: the bit is written to position SIZE-1-k.
  - Positions are written directly; no shifting of earlier bits.
- enable=1, counter < FRAME-1: store bit, counter+1.
- enable=1, counter == FRAME-1 (frame complete):
  - Counter returns to 0; done=1 for exactly one cycle.
  - The completed word includes the bit sampled this cycle.
  - If out_valid=0, or out_valid && out_ready this cycle: out <= completed word, out_valid=1 next cycle. Latency is one edge after the final bit.
  - Otherwise the word is dropped, out and out_valid are unchanged, and overrun <= 1.
- enable=0: shift register and counter hold indefinitely; no timeout. done=0.
- Handshake:
  - out_valid && out_ready with no completing frame: out_valid <= 0; out retains its value.
  - Completion and acceptance in the same cycle: out_valid stays 1 with the new word; no bubble.
  - out is stable while out_valid=1 && out_ready=0.
- busy = (counter != 0), registered with the counter.
- clear=1: counter=0, shift register=0, out_valid=0, overrun=0, done=0, parity_err=0.
  - out value is retained.
  - A bit presented with enable in the same cycle is discarded.
- Reset mid-word: partial bits are lost; the first bit after reset is bit 0 of a new frame.
- overrun is cleared only by reset or clear.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - FRAME = SIZE+1; the bit after the SIZE data bits is an even-parity bit.
  - The parity bit is never stored in out.
  - On completion, parity_err is loaded alongside out: 1 if the XOR of data bits and parity bit is 1.
  - The word is delivered even on mismatch.
  - Dropped words do not update parity_err.
- Undefined: FRAME = SIZE; parity_err is tied to 0.

Test Plan:
- LSB-first delivery: SIZE=8, SHIFT_DIR=0; bits 1,0,1,0,0,1,0,1 on consecutive enabled cycles, out_ready=1 -> out=0xA5 and out_valid=1 one edge after the 8th bit; done pulses once; busy high bits 2-8 only.
- MSB-first with gaps: SHIFT_DIR=1; same bit sequence with enable toggling 1,0 each cycle -> out=0xA5 after the 8th enabled bit; no bit lost or duplicated.
- Backpressure/overrun:
  - out_ready=0; send 0x11 then 0x22 -> out=0x11 with out_valid held and overrun=1.
  - Then out_ready=1 for one cycle -> out_valid=0.
  - Then clear -> overrun=0.
- Simultaneous complete+accept: send 0x3C, hold out_ready=0; raise out_ready on the final bit of 0xC3 -> out=0xC3, out_valid never drops, overrun=0.
- Clear and reset mid-word: 4 bits sent, clear asserted, then 0x5A sent -> out=0x5A. Repeat with async reset mid-word -> all outputs 0 immediately, next frame correct.
- Parity (SIPO_PARITY_EN):
  - 0xA5 followed by parity bit 0 -> parity_err=0.
  - 0xA5 followed by parity bit 1 -> out=0xA5, parity_err=1.
